flash_reader: RTL and testbench



---
 rtl/flash_reader.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_flash_reader.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_reader.sv
// flash_reader: drives the SPI flash controller register bus through a
// READ (0x03) command and streams the returned bytes out over valid/ready.
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_start, i_addr, i_len     job request, 24-bit address, byte count
//   o_busy, o_done, o_err      job status
//   o_valid, o_data, i_ready   output byte stream
//   o_fl_*, i_fl_*             controller register access bus
module flash_reader #(
  parameter logic [7:0]  BR_DIV   = 8'h07,
  parameter logic [7:0]  CS_ON    = 8'h0E,
  parameter logic [7:0]  CS_OFF   = 8'h0F,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [23:0] i_addr,
  input  logic [15:0] i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_valid,
  output logic [7:0]  o_data,
  input  logic        i_ready,
  output logic        o_fl_en,
  output logic        o_fl_wr,
  output logic [3:0]  o_fl_addr,
  output logic [7:0]  o_fl_data,
  input  logic        i_fl_ack,
  input  logic [7:0]  i_fl_data
);

  localparam logic [3:0] SPI_CR2  = 4'h2;
  localparam logic [3:0] SPI_BR   = 4'h3;
  localparam logic [3:0] SPI_CSR  = 4'h4;
  localparam logic [3:0] SPI_SR   = 4'h6;
  localparam logic [3:0] SPI_TXDR = 4'h7;
  localparam logic [3:0] SPI_RXDR = 4'h8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CR2,
    S_BR,
    S_CS_LO,
    S_TX_POLL,
    S_TX_WR,
    S_RX_POLL,
    S_RX_RD,
    S_EMIT,
    S_CS_HI,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [23:0] addr_q, addr_n;
  logic [15:0] rem, rem_n;
  logic [15:0] poll, poll_n;
  logic [2:0]  idx, idx_n;

  logic        en_n, wr_n;
  logic [3:0]  fa_n;
  logic [7:0]  fd_n;
  logic        busy_n, done_n, err_n;
  logic        valid_n;
  logic [7:0]  data_n;

  logic        acc;
  logic        req_wr;
  logic [3:0]  req_a;
  logic [7:0]  req_d;
  logic        acked;
  logic        poll_end;
  logic        cmd_ph;
  logic [7:0]  tx_byte;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      rem       <= '0;
      poll      <= '0;
      idx       <= '0;
      o_fl_en   <= 1'b0;
      o_fl_wr   <= 1'b0;
      o_fl_addr <= 4'h0;
      o_fl_data <= 8'h00;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= 8'h00;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      rem       <= rem_n;
      poll      <= poll_n;
      idx       <= idx_n;
      o_fl_en   <= en_n;
      o_fl_wr   <= wr_n;
      o_fl_addr <= fa_n;
      o_fl_data <= fd_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
      o_err     <= err_n;
      o_valid   <= valid_n;
      o_data    <= data_n;
    end
  end

  assign acked    = o_fl_en && i_fl_ack;
  assign cmd_ph   = !idx[2];
  assign poll_end =
    ({1'b0, poll} + 17'd1) >= {1'b0, POLL_MAX};

  always_comb begin
    tx_byte = 8'h00;
    unique case (idx)
      3'd0:    tx_byte = 8'h03;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    rem_n   = rem;
    poll_n  = poll;
    idx_n   = idx;
    en_n    = o_fl_en;
    wr_n    = o_fl_wr;
    fa_n    = o_fl_addr;
    fd_n    = o_fl_data;
    busy_n  = o_busy;
    done_n  = 1'b0;
    err_n   = o_err;
    valid_n = o_valid;
    data_n  = o_data;
    acc     = 1'b0;
    req_wr  = 1'b0;
    req_a   = 4'h0;
    req_d   = 8'h00;

    unique case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (i_start) begin
          addr_n = i_addr;
          rem_n  = i_len;
          err_n  = 1'b0;
          idx_n  = 3'd0;
          poll_n = 16'd0;
          if (i_len == 16'd0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_CR2;
            busy_n  = 1'b1;
          end
        end
      end
      S_CR2: begin
        acc    = 1'b1;
        req_wr = 1'b1;
        req_a  = SPI_CR2;
        req_d  = 8'hC0;
        if (acked) begin
          en_n    = 1'b0;
          state_n = S_BR;
        end
      end
      S_BR: begin
        acc    = 1'b1;
        req_wr = 1'b1;
        req_a  = SPI_BR;
        req_d  = BR_DIV;
        if (acked) begin
          en_n    = 1'b0;
          state_n = S_CS_LO;
        end
      end
      S_CS_LO: begin
        acc    = 1'b1;
        req_wr = 1'b1;
        req_a  = SPI_CSR;
        req_d  = CS_ON;
        if (acked) begin
          en_n    = 1'b0;
          idx_n   = 3'd0;
          poll_n  = 16'd0;
          state_n = S_TX_POLL;
        end
      end
      S_TX_POLL: begin
        acc   = 1'b1;
        req_a = SPI_SR;
        if (acked) begin
          en_n = 1'b0;
          if (i_fl_data[4]) begin
            state_n = S_TX_WR;
          end else if (poll_end) begin
            err_n   = 1'b1;
            state_n = S_CS_HI;
          end else begin
            poll_n = poll + 16'd1;
          end
        end
      end
      S_TX_WR: begin
        acc    = 1'b1;
        req_wr = 1'b1;
        req_a  = SPI_TXDR;
        req_d  = tx_byte;
        if (acked) begin
          en_n    = 1'b0;
          poll_n  = 16'd0;
          state_n = S_RX_POLL;
        end
      end
      S_RX_POLL: begin
        acc   = 1'b1;
        req_a = SPI_SR;
        if (acked) begin
          en_n = 1'b0;
          if (i_fl_data[3]) begin
            state_n = S_RX_RD;
          end else if (poll_end) begin
            err_n   = 1'b1;
            state_n = S_CS_HI;
          end else begin
            poll_n = poll + 16'd1;
          end
        end
      end
      S_RX_RD: begin
        acc   = 1'b1;
        req_a = SPI_RXDR;
        if (acked) begin
          en_n = 1'b0;
          if (cmd_ph) begin
            idx_n   = idx + 3'd1;
            poll_n  = 16'd0;
            state_n = S_TX_POLL;
          end else begin
            data_n  = i_fl_data;
            valid_n = 1'b1;
            state_n = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (i_ready) begin
          valid_n = 1'b0;
          rem_n   = rem - 16'd1;
          if (rem == 16'd1) begin
            state_n = S_CS_HI;
          end else begin
            poll_n  = 16'd0;
            state_n = S_TX_POLL;
          end
        end
      end
      S_CS_HI: begin
        acc    = 1'b1;
        req_wr = 1'b1;
        req_a  = SPI_CSR;
        req_d  = CS_OFF;
        if (acked) begin
          en_n    = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A new access starts only after a cycle with en low,
    // which gives the controller its idle gap between accesses.
    if (acc && !o_fl_en) begin
      en_n = 1'b1;
      wr_n = req_wr;
      fa_n = req_a;
      fd_n = req_d;
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader: directed bench for flash_reader with a behavioural
// SPI controller + flash model, write log and stream monitor.
module tb_flash_reader;

  localparam logic [3:0] SPI_CR2  = 4'h2;
  localparam logic [3:0] SPI_BR   = 4'h3;
  localparam logic [3:0] SPI_CSR  = 4'h4;
  localparam logic [3:0] SPI_SR   = 4'h6;
  localparam logic [3:0] SPI_TXDR = 4'h7;
  localparam logic [3:0] SPI_RXDR = 4'h8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [23:0] i_addr = '0;
  logic [15:0] i_len = '0;
  logic        o_busy, o_done, o_err, o_valid;
  logic [7:0]  o_data;
  logic        i_ready = 1'b1;
  logic        o_fl_en, o_fl_wr;
  logic [3:0]  o_fl_addr;
  logic [7:0]  o_fl_data;
  logic        fl_ack = 1'b0;
  logic [7:0]  fl_rd = 8'h00;

  int total = 0;
  int bad = 0;

  int ack_dly = 0;
  int stall = 0;
  logic rr_stuck = 1'b0;

  int dcnt = 0;
  int nbytes = 0;
  int sr_cnt = 0;
  logic [23:0] faddr = '0;
  logic [7:0]  rxb = 8'h00;
  logic [7:0]  resp;
  logic        rdy;

  logic [11:0] wlog[$];
  logic [7:0]  strm[$];
  logic [3:0]  exp_a[$];
  logic [7:0]  exp_d[$];
  int rx_polls = 0;
  int en_cyc = 0;
  int txv_bad = 0;
  int stab_bad = 0;
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  logic [7:0] prev_d = 8'h00;

  flash_reader #(.POLL_MAX(16'h0010)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_start(i_start), .i_addr(i_addr),
    .i_len(i_len), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err),
    .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_fl_en(o_fl_en),
    .o_fl_wr(o_fl_wr), .o_fl_addr(o_fl_addr),
    .o_fl_data(o_fl_data), .i_fl_ack(fl_ack),
    .i_fl_data(fl_rd)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    rdy = (sr_cnt >= stall);
    resp = 8'h00;
    if (o_fl_addr == SPI_SR)
      resp = {3'b000, rdy, rdy && !rr_stuck, 3'b000};
    else if (o_fl_addr == SPI_RXDR)
      resp = rxb;
  end

  always @(posedge i_clk) begin
    if (o_fl_en && !fl_ack) begin
      if (dcnt >= ack_dly) begin
        fl_ack <= 1'b1;
        dcnt <= 0;
        fl_rd <= resp;
        if (o_fl_wr && o_fl_addr == SPI_TXDR) begin
          if (nbytes < 4) rxb <= 8'hFF;
          else rxb <= 8'(faddr + 24'(nbytes) - 24'd4);
          if (nbytes >= 1 && nbytes <= 3)
            faddr <= {faddr[15:0], o_fl_data};
          nbytes <= nbytes + 1;
          sr_cnt <= 0;
        end else if (o_fl_wr && o_fl_addr == SPI_CSR
                     && o_fl_data == 8'h0E) begin
          nbytes <= 0;
        end else if (!o_fl_wr && o_fl_addr == SPI_SR) begin
          sr_cnt <= sr_cnt + 1;
        end else if (!o_fl_wr && o_fl_addr == SPI_RXDR) begin
          sr_cnt <= 0;
        end
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      fl_ack <= 1'b0;
      dcnt <= 0;
    end
  end

  always @(negedge i_clk) begin
    if (o_fl_en && fl_ack) begin
      if (o_fl_wr) wlog.push_back({o_fl_addr, o_fl_data});
      if (o_fl_wr && o_fl_addr == SPI_TXDR) begin
        rx_polls <= 0;
        if (o_valid) txv_bad <= txv_bad + 1;
      end else if (!o_fl_wr && o_fl_addr == SPI_SR) begin
        rx_polls <= rx_polls + 1;
      end
    end
    if (o_fl_en) en_cyc <= en_cyc + 1;
    if (o_valid && i_ready) strm.push_back(o_data);
    if (o_valid && prev_v && !prev_hs && o_data !== prev_d)
      stab_bad <= stab_bad + 1;
    prev_v <= o_valid;
    prev_d <= o_data;
    prev_hs <= o_valid && i_ready;
  end

  function automatic void build_log(input logic [23:0] a,
                                    input int n);
    exp_a.delete();
    exp_d.delete();
    exp_a.push_back(SPI_CR2);  exp_d.push_back(8'hC0);
    exp_a.push_back(SPI_BR);   exp_d.push_back(8'h07);
    exp_a.push_back(SPI_CSR);  exp_d.push_back(8'h0E);
    exp_a.push_back(SPI_TXDR); exp_d.push_back(8'h03);
    exp_a.push_back(SPI_TXDR); exp_d.push_back(a[23:16]);
    exp_a.push_back(SPI_TXDR); exp_d.push_back(a[15:8]);
    exp_a.push_back(SPI_TXDR); exp_d.push_back(a[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(SPI_TXDR); exp_d.push_back(8'h00);
    end
    exp_a.push_back(SPI_CSR);  exp_d.push_back(8'h0F);
  endfunction

  task automatic run_job(input logic [23:0] a,
                         input logic [15:0] n,
                         input int bp, input int mid,
                         output int to, output logic e,
                         output int cyc);
    int w;
    w = 0;
    cyc = 0;
    wlog.delete();
    strm.delete();
    @(posedge i_clk); #1;
    i_addr = a; i_len = n; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    to = 1; e = 1'b0;
    while (cyc < 20000) begin
      if (o_done) begin
        to = 0; e = o_err;
        break;
      end
      if (cyc == mid) begin
        i_start = 1'b1; i_addr = 24'h0; i_len = 16'd9;
      end else begin
        i_start = 1'b0;
      end
      if (bp != 0) begin
        i_ready = o_valid && (w >= 10);
        w = o_valid ? w + 1 : 0;
      end else begin
        i_ready = 1'b1;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge i_clk);
    #1;
    total++;
    if ({o_busy, o_done, o_err, o_valid, o_fl_en,
         o_fl_wr} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=000000",
               {o_busy, o_done, o_err, o_valid, o_fl_en, o_fl_wr});
    end
    total++;
    if ({o_data, o_fl_data, o_fl_addr} !== 20'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=00000",
               {o_data, o_fl_data, o_fl_addr});
    end
    i_rst_n = 1'b1;
  endtask

  task automatic chk_job(input string nm,
                         input logic [23:0] a,
                         input int n, input int to,
                         input logic e);
    logic [7:0] ex;
    total++;
    if (to != 0) begin
      bad++;
      $display("FAIL %s_timeout got=1 want=0", nm);
    end
    total++;
    if (e !== 1'b0) begin
      bad++;
      $display("FAIL %s_err got=%b want=0", nm, e);
    end
    build_log(a, n);
    total++;
    if (wlog.size() != exp_a.size()) begin
      bad++;
      $display("FAIL %s_nwr got=%0d want=%0d",
               nm, wlog.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < wlog.size(); i++) begin
      total++;
      if (wlog[i] !== {exp_a[i], exp_d[i]}) begin
        bad++;
        $display("FAIL %s_wr%0d got=%h want=%h",
                 nm, i, wlog[i], {exp_a[i], exp_d[i]});
      end
    end
    total++;
    if (strm.size() != n) begin
      bad++;
      $display("FAIL %s_nbytes got=%0d want=%0d",
               nm, strm.size(), n);
    end
    for (int i = 0; i < n && i < strm.size(); i++) begin
      ex = 8'(a + 24'(i));
      total++;
      if (strm[i] !== ex) begin
        bad++;
        $display("FAIL %s_byte%0d got=%h want=%h",
                 nm, i, strm[i], ex);
      end
    end
  endtask

  task automatic test_basic;
    int to, cyc;
    logic e;
    run_job(24'h000100, 16'd4, 0, -1, to, e, cyc);
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_at_done got=%b want=0", o_busy);
    end
    chk_job("basic", 24'h000100, 4, to, e);
  endtask

  task automatic test_backpressure;
    int to, cyc, s0, t0;
    logic e;
    s0 = stab_bad;
    t0 = txv_bad;
    run_job(24'h000100, 16'd4, 1, -1, to, e, cyc);
    chk_job("bp", 24'h000100, 4, to, e);
    total++;
    if (stab_bad != s0) begin
      bad++;
      $display("FAIL bp_stable got=%0d want=%0d", stab_bad, s0);
    end
    total++;
    if (txv_bad != t0) begin
      bad++;
      $display("FAIL bp_tx_in_emit got=%0d want=%0d", txv_bad, t0);
    end
  endtask

  task automatic test_slow;
    int to, cyc;
    logic e;
    ack_dly = 5;
    stall = 3;
    run_job(24'h000100, 16'd4, 0, -1, to, e, cyc);
    ack_dly = 0;
    stall = 0;
    chk_job("slow", 24'h000100, 4, to, e);
  endtask

  task automatic test_timeout;
    int to, cyc;
    logic e;
    rr_stuck = 1'b1;
    run_job(24'h000000, 16'd2, 0, -1, to, e, cyc);
    rr_stuck = 1'b0;
    total++;
    if (to != 0 || e !== 1'b1) begin
      bad++;
      $display("FAIL tmo_done_err got=%0d/%b want=0/1", to, e);
    end
    total++;
    if (rx_polls != 16) begin
      bad++;
      $display("FAIL tmo_polls got=%0d want=16", rx_polls);
    end
    total++;
    if (wlog.size() != 5) begin
      bad++;
      $display("FAIL tmo_nwr got=%0d want=5", wlog.size());
    end else begin
      total++;
      if (wlog[4] !== {SPI_CSR, 8'h0F}) begin
        bad++;
        $display("FAIL tmo_cs_off got=%h want=%h",
                 wlog[4], {SPI_CSR, 8'h0F});
      end
    end
    repeat (4) @(posedge i_clk);
    #1;
    total++;
    if (strm.size() != 0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL tmo_stream got=%0d want=0", strm.size());
    end
    total++;
    if (o_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_err_hold got=%b want=1", o_err);
    end
  endtask

  task automatic test_len_zero;
    int to, cyc, e0;
    logic e;
    e0 = en_cyc;
    run_job(24'h000123, 16'd0, 0, -1, to, e, cyc);
    total++;
    if (to != 0 || cyc != 0) begin
      bad++;
      $display("FAIL len0_latency got=%0d want=0", cyc);
    end
    total++;
    if (e !== 1'b0) begin
      bad++;
      $display("FAIL len0_err_clear got=%b want=0", e);
    end
    @(posedge i_clk); #1;
    total++;
    if (o_done !== 1'b0) begin
      bad++;
      $display("FAIL len0_pulse got=%b want=0", o_done);
    end
    total++;
    if (en_cyc != e0) begin
      bad++;
      $display("FAIL len0_en got=%0d want=%0d", en_cyc, e0);
    end
  endtask

  task automatic test_edge_addr;
    int to, cyc;
    logic e;
    run_job(24'hFFFFFE, 16'd3, 0, 40, to, e, cyc);
    chk_job("edge", 24'hFFFFFE, 3, to, e);
  endtask

  task automatic test_back_to_back;
    int to, cyc;
    logic e;
    run_job(24'h000000, 16'd1, 0, -1, to, e, cyc);
    i_addr = 24'h000005; i_len = 16'd1; i_start = 1'b1;
    wlog.delete();
    strm.delete();
    @(posedge i_clk); #1;
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got=%b want=1", o_busy);
    end
    to = 1; e = 1'b0; cyc = 0;
    while (cyc < 20000) begin
      if (o_done) begin
        to = 0; e = o_err;
        break;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    chk_job("b2b", 24'h000005, 1, to, e);
  endtask

  task automatic test_midreset;
    int to, cyc;
    logic e;
    wlog.delete();
    strm.delete();
    @(posedge i_clk); #1;
    i_addr = 24'h000100; i_len = 16'd4; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 0;
    while (strm.size() < 1 && cyc < 5000) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    total++;
    if (strm.size() < 1) begin
      bad++;
      $display("FAIL mrst_reach got=0 want=1");
    end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    total++;
    if ({o_busy, o_done, o_err, o_valid, o_fl_en, o_fl_wr,
         o_data, o_fl_data, o_fl_addr} !== 26'h0) begin
      bad++;
      $display("FAIL mrst_outputs got=%h want=0",
               {o_busy, o_done, o_err, o_valid, o_fl_en, o_fl_wr,
                o_data, o_fl_data, o_fl_addr});
    end
    i_rst_n = 1'b1;
    run_job(24'h000000, 16'd1, 0, -1, to, e, cyc);
    chk_job("mrst", 24'h000000, 1, to, e);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_slow();
    test_timeout();
    test_len_zero();
    test_edge_addr();
    test_back_to_back();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
